dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port `data_mem` (8-bit address, 8-bit data, synchronous write, combinational read) between the processor core and a host/loader port. The core has fixed priority, and a starvation counter forces a host slot after `STARVE` denied cycles. Read data is registered and returned to the winning requester one cycle after the grant. The block sits between the core's load/store datapath and `data_mem`, and drives the core's stall.

---
 rtl/dmem_arbiter.sv | 89 ++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/host arbiter for the single-port data_mem
// Core has fixed priority; a saturating starvation counter forces a host slot.
module dmem_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int STARVE = 4
) (
  input  logic          CLK,
  input  logic          start,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_C = 4'(STARVE);

  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          core_rvalid_q, host_rvalid_q;
  logic [DW-1:0] core_rdata_q, host_rdata_q;
  logic          force_host, core_gnt;

  assign force_host = host_req && (wait_cnt_q == STARVE_C);
  assign host_gnt   = !start && host_req && (!core_req || force_host);
  assign core_gnt   = !start && core_req && !host_gnt;
  assign core_stall = core_req && !core_gnt;

  always_comb begin
    mem_addr  = core_addr;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (host_gnt) begin
      mem_addr  = host_addr;
      mem_we    = host_we;
      mem_wdata = host_wdata;
    end else if (core_gnt) begin
      mem_addr  = core_addr;
      mem_we    = core_we;
      mem_wdata = core_wdata;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (host_gnt)
      wait_cnt_d = 4'd0;
    else if (host_req && (wait_cnt_q != STARVE_C))
      wait_cnt_d = wait_cnt_q + 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (start) begin
      wait_cnt_q    <= 4'd0;
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
      core_rdata_q  <= '0;
      host_rdata_q  <= '0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      core_rvalid_q <= core_gnt && !core_we;
      host_rvalid_q <= host_gnt && !host_we;
      if (core_gnt && !core_we)
        core_rdata_q <= mem_rdata;
      if (host_gnt && !host_we)
        host_rdata_q <= mem_rdata;
    end
  end

  // A reset landing in the return cycle kills the pending rvalid immediately.
  assign core_rvalid = core_rvalid_q && !start;
  assign host_rvalid = host_rvalid_q && !start;
  assign core_rdata  = core_rdata_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic       CLK = 1'b0;
  logic       start;
  logic       core_req, core_we, core_stall, core_rvalid;
  logic [7:0] core_addr, core_wdata, core_rdata;
  logic       host_req, host_we, host_gnt, host_rvalid;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
  logic [7:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.AW(8), .DW(8), .STARVE(4)) dut (
    .CLK(CLK), .start(start),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // data_mem model: synchronous write, combinational read
  always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic set_core(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    core_req = req; core_we = we; core_addr = a; core_wdata = d;
  endtask

  task automatic set_host(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    host_req = req; host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic test_reset;
    start = 1'b1;
    set_core(1'b1, 1'b1, 8'h01, 8'hFF);
    set_host(1'b1, 1'b1, 8'h02, 8'hEE);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we cyc%0d got %b exp 0", i, mem_we); end
      checks++;
      if (core_stall !== 1'b1) begin errors++; $display("FAIL reset_core_stall cyc%0d got %b exp 1", i, core_stall); end
      checks++;
      if (host_gnt !== 1'b0) begin errors++; $display("FAIL reset_host_gnt cyc%0d got %b exp 0", i, host_gnt); end
      @(posedge CLK); @(negedge CLK);
    end
    start = 1'b0;
    set_core(1'b0, 1'b0, 8'h00, 8'h00);
    set_host(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checks++;
    if (core_rvalid !== 1'b0 || host_rvalid !== 1'b0) begin
      errors++; $display("FAIL reset_rvalid got core=%b host=%b exp 0/0", core_rvalid, host_rvalid);
    end
    checks++;
    if (core_rdata !== 8'h00 || host_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_rdata got core=%h host=%h exp 00/00", core_rdata, host_rdata);
    end
    @(negedge CLK);
  endtask

  task automatic test_core_store_load;
    set_core(1'b1, 1'b1, 8'h10, 8'hA5);
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 8'hA5) begin
      errors++; $display("FAIL core_store_mux got we=%b a=%h d=%h exp 1/10/a5", mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if (core_stall !== 1'b0) begin errors++; $display("FAIL core_store_stall got %b exp 0", core_stall); end
    @(negedge CLK);
    set_core(1'b1, 1'b0, 8'h10, 8'h00);
    #1;
    checks++;
    if (core_stall !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL core_load_grant got stall=%b we=%b exp 0/0", core_stall, mem_we);
    end
    @(negedge CLK);
    checks++;
    if (core_rvalid !== 1'b1 || core_rdata !== 8'hA5) begin
      errors++; $display("FAIL core_load_return got rvalid=%b rdata=%h exp 1/a5", core_rvalid, core_rdata);
    end
    checks++;
    if (host_rvalid !== 1'b0) begin errors++; $display("FAIL core_load_host_rvalid got %b exp 0", host_rvalid); end
    set_core(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge CLK);
    checks++;
    if (core_rvalid !== 1'b0 || core_rdata !== 8'hA5) begin
      errors++; $display("FAIL core_rdata_hold got rvalid=%b rdata=%h exp 0/a5", core_rvalid, core_rdata);
    end
  endtask

  task automatic test_contention;
    logic [9:0] exp_h;
    logic       prev_h;
    exp_h = 10'b1000010000; // bit i = host grant in cycle i+1
    prev_h = 1'b0;
    set_core(1'b1, 1'b0, 8'h20, 8'h00);
    set_host(1'b1, 1'b0, 8'h10, 8'h00);
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (host_gnt !== exp_h[i] || core_stall !== exp_h[i]) begin
        errors++; $display("FAIL contention_cyc%0d got host_gnt=%b stall=%b exp %b", i + 1, host_gnt, core_stall, exp_h[i]);
      end
      checks++;
      if (mem_addr !== (exp_h[i] ? 8'h10 : 8'h20)) begin
        errors++; $display("FAIL contention_addr_cyc%0d got %h exp %h", i + 1, mem_addr, exp_h[i] ? 8'h10 : 8'h20);
      end
      checks++;
      if (host_rvalid !== prev_h || core_rvalid !== (i > 0 && !prev_h)) begin
        errors++; $display("FAIL contention_rvalid_cyc%0d got host=%b core=%b", i + 1, host_rvalid, core_rvalid);
      end
      prev_h = exp_h[i];
      @(negedge CLK);
    end
    set_core(1'b0, 1'b0, 8'h00, 8'h00);
    set_host(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'hA5) begin
      errors++; $display("FAIL contention_host_return got rvalid=%b rdata=%h exp 1/a5", host_rvalid, host_rdata);
    end
    @(negedge CLK);
  endtask

  task automatic test_host_idle_load;
    set_host(1'b1, 1'b1, 8'h80, 8'h3C);
    #1;
    checks++;
    if (host_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h80) begin
      errors++; $display("FAIL host_store got gnt=%b we=%b a=%h exp 1/1/80", host_gnt, mem_we, mem_addr);
    end
    @(negedge CLK);
    set_host(1'b1, 1'b0, 8'h80, 8'h00);
    #1;
    checks++;
    if (host_gnt !== 1'b1) begin errors++; $display("FAIL host_load_gnt got %b exp 1", host_gnt); end
    @(negedge CLK);
    set_host(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'h3C) begin
      errors++; $display("FAIL host_load_return got rvalid=%b rdata=%h exp 1/3c", host_rvalid, host_rdata);
    end
    checks++;
    if (core_rvalid !== 1'b0) begin errors++; $display("FAIL host_load_core_rvalid got %b exp 0", core_rvalid); end
    @(negedge CLK);
  endtask

  task automatic test_host_gap;
    set_core(1'b1, 1'b1, 8'h40, 8'h11);
    set_host(1'b1, 1'b0, 8'h80, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (host_gnt !== 1'b0) begin errors++; $display("FAIL gap_denied_cyc%0d got %b exp 0", i, host_gnt); end
      @(negedge CLK);
    end
    host_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (host_gnt !== 1'b0 || core_stall !== 1'b0) begin
        errors++; $display("FAIL gap_idle_cyc%0d got gnt=%b stall=%b exp 0/0", i, host_gnt, core_stall);
      end
      @(negedge CLK);
    end
    host_req = 1'b1;
    #1;
    checks++;
    if (host_gnt !== 1'b0) begin errors++; $display("FAIL gap_resume1 got %b exp 0", host_gnt); end
    @(negedge CLK);
    #1;
    checks++;
    if (host_gnt !== 1'b1 || core_stall !== 1'b1) begin
      errors++; $display("FAIL gap_resume2 got gnt=%b stall=%b exp 1/1", host_gnt, core_stall);
    end
    @(negedge CLK);
    set_core(1'b0, 1'b0, 8'h00, 8'h00);
    set_host(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_load;
    set_core(1'b1, 1'b0, 8'h80, 8'h00);
    #1;
    checks++;
    if (core_stall !== 1'b0) begin errors++; $display("FAIL midload_grant got stall=%b exp 0", core_stall); end
    @(negedge CLK);
    start = 1'b1;
    set_core(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checks++;
    if (core_rvalid !== 1'b0) begin errors++; $display("FAIL midload_rvalid got %b exp 0", core_rvalid); end
    @(negedge CLK);
    checks++;
    if (core_rdata !== 8'h00 || core_rvalid !== 1'b0) begin
      errors++; $display("FAIL midload_rdata got rdata=%h rvalid=%b exp 00/0", core_rdata, core_rvalid);
    end
    start = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    start = 1'b1;
    set_core(1'b0, 1'b0, 8'h00, 8'h00);
    set_host(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge CLK);
    test_reset;
    test_core_store_load;
    test_contention;
    test_host_idle_load;
    test_host_gap;
    test_reset_mid_load;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
